jtag_cnt_regs: RTL and testbench
================================

JTAG_CNT_REGS -- requirements
Module: jtag_cnt_regs

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: tck and init, as the codebase names them.
REQ-002 SHALL have port `tck  in  1`: the JTAG virtual clock; all state updates on its rising edge.
REQ-003 SHALL have port `init  in  1`: synchronous active-high reset.
REQ-004 SHALL have port `address  in  8`: register address from the JTAG receiver.
REQ-005 SHALL have port `wr_data  in  8`: write data from the JTAG receiver.
REQ-006 SHALL have port `addr_we  in  1`: one-cycle strobe; latch address.
REQ-007 SHALL have port `we  in  1`: one-cycle strobe; write wr_data to the latched address.
REQ-008 SHALL have port `rd_data  out  8`: registered read data; feeds the receiver's capture input.
REQ-009 SHALL have port `event_in  in  1`: asynchronous event line to be counted.
REQ-010 SHALL have port `cnt_en  out  1`: mirror of CTRL.bit1.

Function
REQ-011 SHALL latch cur_addr <= address on the edge where addr_we=1.
REQ-012 SHALL, on the edge where we=1, write wr_data to the register at cur_addr; writes to RO or unmapped addresses are ignored.
REQ-013 SHALL, when addr_we and we are both 1 on the same edge, apply the write to the previously latched cur_addr and latch the new address on that same edge.
REQ-014 SHALL implement this register map:
- 0x00 ID: RO, 0xC3.
- 0x01 CTRL: RW; bit0 soft_reset (self-clearing), bit1 count_enable, bit2 clear (self-clearing).
- 0x02 STATUS: bit0 ovf (sticky, write-1-to-clear), bit1 = count_enable (RO).
- 0x03 SCRATCH: RW.
- 0x10..0x13: counter bytes, LSB first.
- Unmapped addresses read 0x00.
REQ-015 SHALL update rd_data every cycle from cur_addr, so read data is valid one cycle after addr_we and one cycle after any write.
REQ-016 SHALL pass event_in through a 2-flop synchronizer and a rising-edge detector; each detected edge with count_enable=1 increments the 32-bit counter by 1.
REQ-017 SHALL wrap the counter from 0xFFFFFFFF to 0x00000000 and set ovf on that edge.
REQ-018 SHALL, when a CTRL write with bit2=1 occurs, zero the counter and ovf on the next edge; clear has priority over a same-cycle increment and a same-cycle overflow.
REQ-019 SHALL let an ovf set win over a same-cycle STATUS write-1-to-clear.
REQ-020 SHALL, when a CTRL write with bit0=1 occurs, return every register, the counter, cur_addr and rd_data to reset values on the next edge; other bits of that write are discarded.
REQ-021 SHALL keep the synchronizer flops running during soft reset.

Reset
REQ-022 SHALL, when init=1, set cur_addr=0x00, CTRL=0x00, SCRATCH=0x00, ovf=0, counter=0, snapshot=0, rd_data=0x00 and cnt_en=0.
REQ-023 SHALL give init priority over every write, increment and strobe on the same edge.
REQ-024 SHALL not count an edge detected while init=1; an edge detected during reset is lost.

Configuration
REQ-025 SHALL, when JCNT_SNAPSHOT_EN is defined, copy the full 32-bit counter into a snapshot register on the edge where addr_we=1 and address=0x10; addresses 0x10..0x13 then read the snapshot bytes, giving a coherent 32-bit read.
REQ-026 SHALL, when JCNT_SNAPSHOT_EN is undefined, contain no snapshot register; addresses 0x10..0x13 read live counter bytes.

Structure
REQ-027 SHALL place the address constants (ADDR_ID, ADDR_CTRL, ADDR_STATUS, ADDR_SCRATCH, ADDR_CNT0..3), ID_VALUE=8'hC3 and the CTRL/STATUS bit indices in the shared package jtag_cnt_pkg.
REQ-028 SHALL implement the 2-flop synchronizer plus rising-edge detector as the sub-module sync_edge, instantiated once.

Verification
REQ-029 SHALL cover: after init, addr_we with address 0x00 -> rd_data=0xC3 one cycle later.
REQ-030 SHALL cover: address 0x03, we with wr_data 0x5A, re-address 0x03 -> rd_data=0x5A; a write of 0x77 to 0x00 -> ID still reads 0xC3.
REQ-031 SHALL cover: CTRL=0x02, 5 pulses on event_in, read 0x10..0x13 -> bytes 0x05,0x00,0x00,0x00.
REQ-032 SHALL cover: counter forced to 0xFFFFFFFF (or 2^32 pulses in a fast model), 1 pulse -> counter 0 and STATUS=0x03; a write of 0x01 to STATUS -> STATUS=0x02.
REQ-033 SHALL cover: CTRL write 0x01 (soft reset) with SCRATCH=0x5A and counter=7 -> SCRATCH=0x00, counter=0, cnt_en=0.
REQ-034 SHALL cover (JCNT_SNAPSHOT_EN): latch 0x10 at count 0x000000FF, 300 more pulses, read 0x11 -> 0x00.

Source files
------------

// File: rtl/jtag_cnt_pkg.sv
// Shared constants for the JTAG event-counter register block: register map,
// identification value, control/status bit positions and a byte-select helper.
package jtag_cnt_pkg;

    localparam logic [7:0] ADDR_ID      = 8'h00;
    localparam logic [7:0] ADDR_CTRL    = 8'h01;
    localparam logic [7:0] ADDR_STATUS  = 8'h02;
    localparam logic [7:0] ADDR_SCRATCH = 8'h03;
    localparam logic [7:0] ADDR_CNT0    = 8'h10;
    localparam logic [7:0] ADDR_CNT1    = 8'h11;
    localparam logic [7:0] ADDR_CNT2    = 8'h12;
    localparam logic [7:0] ADDR_CNT3    = 8'h13;

    localparam logic [7:0] ID_VALUE = 8'hC3;

    localparam int CTRL_SOFT_RST = 0;
    localparam int CTRL_CNT_EN   = 1;
    localparam int CTRL_CLEAR    = 2;

    localparam int STATUS_OVF    = 0;
    localparam int STATUS_CNT_EN = 1;

    // CTRL bits that drop back to zero one edge after being written
    localparam logic [7:0] CTRL_SELF_CLEAR = 8'h05;

    function automatic logic [7:0] cnt_byte(input logic [31:0] value, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = value[7:0];
            2'd1:    b = value[15:8];
            2'd2:    b = value[23:16];
            2'd3:    b = value[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jtag_cnt_regs_sync_edge.sv
// sync_edge: two-flop synchronizer for an asynchronous line followed by a
// rising-edge detector producing a one-cycle pulse in the clk domain.
module sync_edge
    import jtag_cnt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/jtag_cnt_regs.sv
// jtag_cnt_regs: JTAG-accessible register block with a 32-bit event counter.
// Optional feature macro: JCNT_SNAPSHOT_EN (coherent 32-bit counter snapshot).
module jtag_cnt_regs
    import jtag_cnt_pkg::*;
(
    input  logic       tck,
    input  logic       init,
    input  logic [7:0] address,
    input  logic [7:0] wr_data,
    input  logic       addr_we,
    input  logic       we,
    output logic [7:0] rd_data,
    input  logic       event_in,
    output logic       cnt_en
);

    logic [7:0]  cur_addr_r;
    logic [7:0]  ctrl_r;
    logic [7:0]  scratch_r;
    logic        ovf_r;
    logic [31:0] cnt_r;

    logic        rise_s;
    logic        srst_s;
    logic        clear_s;
    logic        inc_s;
    logic        wrap_s;
    logic        wr_ctrl_s;
    logic        wr_status_s;
    logic        wr_scratch_s;
    logic [7:0]  cur_addr_next_s;
    logic [7:0]  ctrl_next_s;
    logic [7:0]  scratch_next_s;
    logic        ovf_next_s;
    logic [31:0] cnt_next_s;
    logic [7:0]  status_s;
    logic [7:0]  rd_next_s;
    logic [31:0] rd_cnt_s;

    // Synchronizer keeps running through soft reset; only init clears it
    sync_edge u_sync_edge (
        .clk  (tck),
        .rst  (init),
        .din  (event_in),
        .rise (rise_s)
    );

    // Write decode, counter/overflow and control next-state
    always_comb begin
        srst_s       = ctrl_r[CTRL_SOFT_RST];
        clear_s      = ctrl_r[CTRL_CLEAR];
        inc_s        = rise_s & ctrl_r[CTRL_CNT_EN];
        wrap_s       = inc_s & (cnt_r == 32'hFFFF_FFFF);
        wr_ctrl_s    = we & (cur_addr_r == ADDR_CTRL);
        wr_status_s  = we & (cur_addr_r == ADDR_STATUS);
        wr_scratch_s = we & (cur_addr_r == ADDR_SCRATCH);

        if (addr_we) begin
            cur_addr_next_s = address;
        end else begin
            cur_addr_next_s = cur_addr_r;
        end

        // A soft-reset request discards every other bit of the same write
        ctrl_next_s = 8'h00;
        if (wr_ctrl_s) begin
            if (wr_data[CTRL_SOFT_RST]) begin
                ctrl_next_s[CTRL_SOFT_RST] = 1'b1;
            end else begin
                ctrl_next_s = wr_data;
            end
        end else begin
            ctrl_next_s = ctrl_r & ~CTRL_SELF_CLEAR;
        end

        if (wr_scratch_s) begin
            scratch_next_s = wr_data;
        end else begin
            scratch_next_s = scratch_r;
        end

        if (clear_s) begin
            cnt_next_s = 32'h0000_0000;
        end else if (inc_s) begin
            cnt_next_s = cnt_r + 32'd1;
        end else begin
            cnt_next_s = cnt_r;
        end

        // Clear beats overflow; overflow beats write-1-to-clear
        if (clear_s) begin
            ovf_next_s = 1'b0;
        end else if (wrap_s) begin
            ovf_next_s = 1'b1;
        end else if (wr_status_s && wr_data[STATUS_OVF]) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

`ifdef JCNT_SNAPSHOT_EN
    logic [31:0] snap_r;

    // Snapshot taken when the host points at the counter's low byte
    always_ff @(posedge tck) begin
        if (init || srst_s) begin
            snap_r <= 32'h0000_0000;
        end else if (addr_we && (address == ADDR_CNT0)) begin
            snap_r <= cnt_r;
        end else begin
            snap_r <= snap_r;
        end
    end

    assign rd_cnt_s = snap_r;
`else
    assign rd_cnt_s = cnt_r;
`endif

    // Read mux over current register state
    always_comb begin
        status_s                = 8'h00;
        status_s[STATUS_OVF]    = ovf_r;
        status_s[STATUS_CNT_EN] = ctrl_r[CTRL_CNT_EN];
        case (cur_addr_r)
            ADDR_ID:      rd_next_s = ID_VALUE;
            ADDR_CTRL:    rd_next_s = ctrl_r;
            ADDR_STATUS:  rd_next_s = status_s;
            ADDR_SCRATCH: rd_next_s = scratch_r;
            ADDR_CNT0, ADDR_CNT1, ADDR_CNT2, ADDR_CNT3:
                          rd_next_s = cnt_byte(rd_cnt_s, cur_addr_r[1:0]);
            default:      rd_next_s = 8'h00;
        endcase
    end

    // Register state; init and soft reset both return everything to zero
    always_ff @(posedge tck) begin
        if (init || srst_s) begin
            cur_addr_r <= 8'h00;
            ctrl_r     <= 8'h00;
            scratch_r  <= 8'h00;
            ovf_r      <= 1'b0;
            cnt_r      <= 32'h0000_0000;
            rd_data    <= 8'h00;
        end else begin
            cur_addr_r <= cur_addr_next_s;
            ctrl_r     <= ctrl_next_s;
            scratch_r  <= scratch_next_s;
            ovf_r      <= ovf_next_s;
            cnt_r      <= cnt_next_s;
            rd_data    <= rd_next_s;
        end
    end

    assign cnt_en = ctrl_r[CTRL_CNT_EN];

endmodule

// File: tb/tb_jtag_cnt_regs.sv
// Self-checking bench for jtag_cnt_regs: directed vector table, corner-case
// sequences and randomized operations checked against a transaction-level model.
module tb_jtag_cnt_regs;

    logic       tck = 1'b0;
    logic       init;
    logic [7:0] address;
    logic [7:0] wr_data;
    logic       addr_we;
    logic       we;
    logic [7:0] rd_data;
    logic       event_in;
    logic       cnt_en;

    jtag_cnt_regs dut (
        .tck      (tck),
        .init     (init),
        .address  (address),
        .wr_data  (wr_data),
        .addr_we  (addr_we),
        .we       (we),
        .rd_data  (rd_data),
        .event_in (event_in),
        .cnt_en   (cnt_en)
    );

    always #5 tck = ~tck;

    int n_total = 0;
    int n_pass  = 0;

    // Transaction-level model of the visible register state
    logic [7:0]  m_addr;
    logic [7:0]  m_ctrl;
    logic [7:0]  m_scratch;
    logic        m_ovf;
    logic [31:0] m_cnt;
    logic [31:0] m_snap;

    localparam logic [1:0] OP_ADDR  = 2'd0;
    localparam logic [1:0] OP_WR    = 2'd1;
    localparam logic [1:0] OP_PULSE = 2'd2;

    typedef struct {
        logic [1:0] op;
        logic [7:0] val;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, exp);
    endtask

    task automatic m_reset();
        m_addr = 8'h00; m_ctrl = 8'h00; m_scratch = 8'h00;
        m_ovf = 1'b0; m_cnt = 32'h0; m_snap = 32'h0;
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        logic [31:0] src;
        int sh;
`ifdef JCNT_SNAPSHOT_EN
        src = m_snap;
`else
        src = m_cnt;
`endif
        if (a == 8'h00) return 8'hC3;
        if (a == 8'h01) return m_ctrl;
        if (a == 8'h02) return {6'b0, m_ctrl[1], m_ovf};
        if (a == 8'h03) return m_scratch;
        if (a >= 8'h10 && a <= 8'h13) begin
            sh = 8 * int'(a - 8'h10);
            return src[sh +: 8];
        end
        return 8'h00;
    endfunction

    task automatic m_write(input logic [7:0] d);
        if (m_addr == 8'h01) begin
            if (d[0]) m_reset();
            else begin
                m_ctrl = d & 8'hFA;
                if (d[2]) begin m_cnt = 32'h0; m_ovf = 1'b0; end
            end
        end else if (m_addr == 8'h02) begin
            if (d[0]) m_ovf = 1'b0;
        end else if (m_addr == 8'h03) begin
            m_scratch = d;
        end
    endtask

    task automatic set_addr(input logic [7:0] a);
        @(negedge tck); address = a; addr_we = 1'b1;
        @(negedge tck); addr_we = 1'b0;
        m_addr = a;
`ifdef JCNT_SNAPSHOT_EN
        if (a == 8'h10) m_snap = m_cnt;
`endif
        @(negedge tck);
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge tck); wr_data = d; we = 1'b1;
        @(negedge tck); we = 1'b0;
        repeat (2) @(negedge tck);
        m_write(d);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge tck); event_in = 1'b1;
            repeat (2) @(negedge tck);
            event_in = 1'b0;
            @(negedge tck);
            if (m_ctrl[1]) begin
                if (m_cnt == 32'hFFFF_FFFF) m_ovf = 1'b1;
                m_cnt = m_cnt + 32'd1;
            end
        end
        repeat (4) @(negedge tck);
    endtask

    task automatic force_full();
        @(negedge tck); force dut.cnt_r = 32'hFFFF_FFFF;
        @(negedge tck); release dut.cnt_r;
        m_cnt = 32'hFFFF_FFFF;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pick [8];
        logic [7:0] a;
        logic [7:0] d;
        int r;
        pick = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13};

        vecs[0]  = '{OP_ADDR,  8'h00, 8'hC3, "id_after_init"};
        vecs[1]  = '{OP_ADDR,  8'h03, 8'h00, "scratch_reset"};
        vecs[2]  = '{OP_WR,    8'h5A, 8'h5A, "scratch_write"};
        vecs[3]  = '{OP_ADDR,  8'h01, 8'h00, "ctrl_reset"};
        vecs[4]  = '{OP_ADDR,  8'h03, 8'h5A, "scratch_readback"};
        vecs[5]  = '{OP_ADDR,  8'h00, 8'hC3, "id_reread"};
        vecs[6]  = '{OP_WR,    8'h77, 8'hC3, "id_read_only"};
        vecs[7]  = '{OP_ADDR,  8'h55, 8'h00, "unmapped_read"};
        vecs[8]  = '{OP_WR,    8'h12, 8'h00, "unmapped_write"};
        vecs[9]  = '{OP_ADDR,  8'h01, 8'h00, "ctrl_read"};
        vecs[10] = '{OP_WR,    8'h02, 8'h02, "ctrl_enable"};
        vecs[11] = '{OP_PULSE, 8'd5,  8'h02, "ctrl_after_pulses"};
        vecs[12] = '{OP_ADDR,  8'h02, 8'h02, "status_enabled"};
        vecs[13] = '{OP_ADDR,  8'h10, 8'h05, "cnt_byte0"};
        vecs[14] = '{OP_ADDR,  8'h11, 8'h00, "cnt_byte1"};
        vecs[15] = '{OP_ADDR,  8'h12, 8'h00, "cnt_byte2"};
        vecs[16] = '{OP_ADDR,  8'h13, 8'h00, "cnt_byte3"};
        vecs[17] = '{OP_ADDR,  8'h01, 8'h02, "ctrl_reread"};
        vecs[18] = '{OP_WR,    8'h06, 8'h02, "ctrl_clear_selfclr"};
        vecs[19] = '{OP_ADDR,  8'h10, 8'h00, "cnt_cleared"};

        init = 1'b1; addr_we = 1'b0; we = 1'b0; event_in = 1'b0;
        address = 8'h00; wr_data = 8'h00;
        m_reset();
        repeat (3) @(negedge tck);
        check("reset_rd_data", rd_data, 8'h00);
        check("reset_cnt_en", {7'b0, cnt_en}, 8'h00);
        init = 1'b0;
        @(negedge tck);

        for (int i = 0; i < 20; i++) begin
            case (vecs[i].op)
                OP_ADDR:  set_addr(vecs[i].val);
                OP_WR:    wr(vecs[i].val);
                default:  pulses(int'(vecs[i].val));
            endcase
            check(vecs[i].name, rd_data, vecs[i].exp);
        end
        check("cnt_en_mirror", {7'b0, cnt_en}, 8'h01);

        // Wrap from all-ones sets ovf; write-1-to-clear drops it
        set_addr(8'h02);
        force_full();
        pulses(1);
        check("ovf_status", rd_data, 8'h03);
        set_addr(8'h10); check("wrap_byte0", rd_data, 8'h00);
        set_addr(8'h13); check("wrap_byte3", rd_data, 8'h00);
        set_addr(8'h02);
        wr(8'h01);
        check("ovf_w1c", rd_data, 8'h02);

        // Overflow and write-1-to-clear on the same edge: overflow wins
        force_full();
        event_in = 1'b1;
        repeat (2) @(negedge tck);
        wr_data = 8'h01; we = 1'b1;
        @(negedge tck); we = 1'b0; event_in = 1'b0;
        repeat (4) @(negedge tck);
        m_cnt = 32'h0; m_ovf = 1'b1;
        check("ovf_beats_w1c", rd_data, 8'h03);
        wr(8'h01);
        check("ovf_cleared_again", rd_data, 8'h02);

        // Clear lands on the same edge as a wrapping increment: clear wins
        set_addr(8'h01);
        force_full();
        event_in = 1'b1;
        @(negedge tck); wr_data = 8'h06; we = 1'b1;
        @(negedge tck); we = 1'b0; event_in = 1'b0;
        repeat (4) @(negedge tck);
        m_cnt = 32'h0; m_ovf = 1'b0; m_ctrl = 8'h02;
        set_addr(8'h02); check("clear_beats_ovf", rd_data, 8'h02);
        set_addr(8'h10); check("clear_beats_inc", rd_data, 8'h00);

        // Soft reset with scratch and counter populated
        set_addr(8'h03); wr(8'h5A);
        pulses(7);
        set_addr(8'h10); check("cnt_seven", rd_data, 8'h07);
        set_addr(8'h01); wr(8'h01);
        check("srst_addr_to_id", rd_data, 8'hC3);
        check("srst_cnt_en", {7'b0, cnt_en}, 8'h00);
        set_addr(8'h03); check("srst_scratch", rd_data, 8'h00);
        set_addr(8'h10); check("srst_cnt", rd_data, 8'h00);

`ifdef JCNT_SNAPSHOT_EN
        set_addr(8'h01); wr(8'h02);
        pulses(255);
        set_addr(8'h10); check("snap_byte0", rd_data, 8'hFF);
        pulses(300);
        set_addr(8'h11); check("snap_byte1_coherent", rd_data, 8'h00);
`endif

        // Randomized operations against the model
        for (int it = 0; it < 80; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) begin
                r = int'($urandom_range(0, 8));
                a = (r == 8) ? 8'($urandom) : pick[r];
                set_addr(a);
            end else if (r < 7) begin
                d = 8'($urandom);
                if (m_addr == 8'h01 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
                wr(d);
            end else begin
                pulses(int'($urandom_range(0, 6)));
            end
            check("rand_rd_data", rd_data, m_read(m_addr));
            check("rand_cnt_en", {7'b0, cnt_en}, {7'b0, m_ctrl[1]});
        end

        // init overrides a same-edge address latch and write
        set_addr(8'h03); wr(8'h11);
        check("scratch_pre_init", rd_data, 8'h11);
        @(negedge tck);
        init = 1'b1; addr_we = 1'b1; address = 8'h03; we = 1'b1; wr_data = 8'h99;
        repeat (2) @(negedge tck);
        init = 1'b0; addr_we = 1'b0; we = 1'b0;
        m_reset();
        @(negedge tck);
        check("init_priority_addr", rd_data, 8'hC3);
        set_addr(8'h03); check("init_priority_scratch", rd_data, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
